beat_datapath: RTL and testbench
================================

// Module: beat_datapath
// PURPOSE
//  Datapath paired with the sequencer control FSM; sits directly downstream of it.
//  Captures the four 8-step instrument patterns and the BPM from data_in when the FSM
//  asserts the ld_* strobes.
//  Generates the eighth-note tempo pulse (beat_tick) that advances the FSM's beat loop.
//  Converts the FSM's beat index (timing) into per-instrument trigger pulses and timed gates.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency; eighth-note threshold ACC_MAX = CLK_HZ*30
//  GATE_CYCLES  2_500_000   gate[i] high time after a trigger, in clk cycles (>=1)
//  ACC_W        32          tempo accumulator width; must hold ACC_MAX+255
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-low reset
//  data_in     in   8  pattern bits / BPM value from switches
//  ld_ins1..4  in   1  load data_in into pattern register 1..4
//  ld_bpm      in   1  load data_in into bpm register
//  play        in   1  run enable from control FSM
//  timing      in   4  beat index from FSM: 0 = wait, 1..8 = step
//  beat_tick   out  1  one-clk pulse per eighth note; drives FSM step advance
//  trig        out  4  one-clk pulse per instrument when its step bit is set
//  gate        out  4  per-instrument gate, high GATE_CYCLES after trig
//  step_led    out  8  one-hot of current step (bit timing-1); 0 when timing 0 or >8
//  bpm_zero    out  1  high while stored bpm == 0
// BEHAVIOUR
//  Reset (reset=0 at posedge): patterns, bpm, acc, prev_timing, gate counters := 0.
//    All outputs 0; bpm_zero then reflects bpm == 0, i.e. 1.
//  Loads: on posedge with ld_insN=1 and play=0, patN := data_in; same for ld_bpm -> bpm.
//    Strobes are independent; several high in one cycle each load data_in.
//    All loads are ignored while play=1.
//  Tempo NCO, registered, 1-cycle latency:
//    If play=0 or bpm=0: acc := 0, beat_tick := 0.
//    Else with sum = acc + bpm:
//      if sum >= ACC_MAX: acc := sum - ACC_MAX, beat_tick := 1;
//      else acc := sum, beat_tick := 0.
//    Result: one tick every ACC_MAX/bpm cycles on average; residue carries, no drift.
//  Trigger detect FSM, states:
//    IDLE: play=0. trig, gate, and prev_timing forced to 0.
//    ARMED: play=1, timing=0.
//    RUN: play=1, timing 1..8.
//    IDLE->ARMED on play=1; ARMED->RUN when timing enters 1..8; any->IDLE on play=0.
//  Edge rule: when timing != prev_timing and 1 <= timing <= 8:
//    trig[i] := pat(i+1)[timing-1] for exactly one cycle (1 clk after the change).
//    prev_timing := timing every cycle.
//  Wrap 8->1 counts as a change and retriggers; timing 9..15 or 0 produces no trig.
//  Gate counters (one per instrument), on the trig cycle:
//    Load with GATE_CYCLES when trig[i] is asserted; retrigger reloads the counter.
//    Otherwise decrement to 0; gate[i] = (cnt != 0).
//  play falling edge: next posedge clears trig, gate counters, and acc.
//    Patterns and bpm are retained.
//  step_led: combinational decode of timing.
// TESTING (CLK_HZ=100 -> ACC_MAX=3000, GATE_CYCLES=4)
//  1. reset=0 for 2 clks with data_in=8'hFF and every ld_* high
//     -> all outputs 0 except bpm_zero=1; no loads occur.
//  2. ld_bpm with data_in=120, then play=1
//     -> first beat_tick 25 clks after play, then exactly every 25 clks.
//  3. pat1=8'b0000_0101, play=1, timing 0->1->2->3
//     -> trig[0] pulses 1 clk after the steps to 1 and 3 only;
//        gate[0] high 4 clks after each trig; step_led=8'h01, 8'h02, 8'h04.
//  4. bpm=0, play=1 for 10_000 clks -> beat_tick never asserts; bpm_zero=1.
//  5. play=1, ld_ins2 with data_in=8'hAA -> pat2 unchanged.
//     Drop play mid-gate -> gate=0 and acc=0 on the next clk.
//  6. pat4=8'h81, timing 8->1, then timing=9
//     -> trig[3] pulses on both 8 and 1; no trig and step_led=0 at timing=9.

Source files
------------

// File: rtl/beat_datapath_if.sv
// Handshake bundle between the sequencer control FSM and the beat datapath.
// The FSM side is the master; the datapath side is the slave.
interface beat_datapath_if;
  logic [7:0] data_in;
  logic       ld_ins1;
  logic       ld_ins2;
  logic       ld_ins3;
  logic       ld_ins4;
  logic       ld_bpm;
  logic       play;
  logic [3:0] timing;
  logic       beat_tick;
  logic [3:0] trig;
  logic [3:0] gate;
  logic [7:0] step_led;
  logic       bpm_zero;

  modport master (
    output data_in, ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm, play, timing,
    input  beat_tick, trig, gate, step_led, bpm_zero
  );

  modport slave (
    input  data_in, ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm, play, timing,
    output beat_tick, trig, gate, step_led, bpm_zero
  );
endinterface

// File: rtl/beat_datapath.sv
// Sequencer datapath: pattern/BPM capture, eighth-note tempo NCO, and per-step
// trigger/gate generation for four instruments. Outputs are registered except step_led/bpm_zero.
module beat_datapath #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 2_500_000,
  parameter int ACC_W       = 32
) (
  input  logic           clk,
  input  logic           reset,
  beat_datapath_if.slave bus
);

  localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(longint'(CLK_HZ) * 30);
  localparam int               CNT_W     = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                  state;
  logic [3:0][7:0]         pat;
  logic [7:0]              bpm;
  logic [ACC_W-1:0]        acc;
  logic [3:0]              prev_timing;
  logic [3:0][CNT_W-1:0]   cnt;
  logic [3:0]              trig_q;
  logic                    tick_q;

  logic                    step_valid;
  logic [2:0]              step_idx;
  logic [ACC_W-1:0]        sum;
  logic [3:0]              trig_next;

  assign step_valid = (bus.timing >= 4'd1) && (bus.timing <= 4'd8);
  assign step_idx   = 3'(bus.timing - 4'd1);
  assign sum        = acc + ACC_W'(bpm);

  // A trigger fires only on the first cycle of a new step; a held step stays quiet.
  always_comb begin
    trig_next = '0;
    if (bus.play && step_valid && (bus.timing != prev_timing)) begin
      for (int i = 0; i < 4; i++) begin
        trig_next[i] = pat[i][step_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pat         <= '0;
      bpm         <= '0;
      acc         <= '0;
      prev_timing <= '0;
      cnt         <= '0;
      trig_q      <= '0;
      tick_q      <= 1'b0;
    end else begin
      if (!bus.play) begin
        if (bus.ld_ins1) pat[0] <= bus.data_in;
        if (bus.ld_ins2) pat[1] <= bus.data_in;
        if (bus.ld_ins3) pat[2] <= bus.data_in;
        if (bus.ld_ins4) pat[3] <= bus.data_in;
        if (bus.ld_bpm)  bpm    <= bus.data_in;
      end

      case (state)
        IDLE:    if (bus.play) state <= ARMED;
        ARMED:   if (!bus.play) state <= IDLE;
                 else if (step_valid) state <= RUN;
        RUN:     if (!bus.play) state <= IDLE;
                 else if (!step_valid) state <= ARMED;
        default: state <= IDLE;
      endcase

      if (!bus.play) begin
        trig_q      <= '0;
        prev_timing <= '0;
        cnt         <= '0;
      end else begin
        trig_q      <= trig_next;
        prev_timing <= bus.timing;
        for (int i = 0; i < 4; i++) begin
          if (trig_next[i]) cnt[i] <= GATE_LOAD;
          else if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end

      // Residue is kept on wrap so the long-run tick rate is exact.
      if (!bus.play || (bpm == 8'd0)) begin
        acc    <= '0;
        tick_q <= 1'b0;
      end else if (sum >= ACC_MAX) begin
        acc    <= sum - ACC_MAX;
        tick_q <= 1'b1;
      end else begin
        acc    <= sum;
        tick_q <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.gate[i] = (cnt[i] != '0);
    end
  end

  assign bus.trig      = trig_q;
  assign bus.beat_tick = tick_q;
  assign bus.bpm_zero  = (bpm == 8'd0);
  assign bus.step_led  = step_valid ? (8'd1 << step_idx) : 8'd0;

endmodule

// File: tb/tb_beat_datapath.sv
// Bench for beat_datapath: directed scenarios plus random traffic, compared
// cycle by cycle against a timestamp/arithmetic model of the sequencer rules.
module tb_beat_datapath;
  localparam int ACC_MAX = 3000;
  localparam int GATE    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  beat_datapath_if bus();

  beat_datapath #(.CLK_HZ(100), .GATE_CYCLES(GATE), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  longint     cyc = 0;
  logic [7:0] pat_m [4];
  int         bpm_m;
  int         prev_m;
  longint     k_m;
  logic       tick_e;
  logic [3:0] trig_e;
  logic       gate_on [4];
  longint     trig_at [4];

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: tick when floor(k*bpm/ACC_MAX) steps up; gate high for GATE cycles from the trigger stamp.
  task automatic model_edge();
    int t;
    cyc++;
    t = int'(bus.timing);
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        pat_m[i]   = 8'h00;
        gate_on[i] = 1'b0;
      end
      bpm_m  = 0;
      prev_m = 0;
      k_m    = 0;
      tick_e = 1'b0;
      trig_e = 4'h0;
    end else begin
      trig_e = 4'h0;
      if (bus.play && t >= 1 && t <= 8 && t != prev_m) begin
        for (int i = 0; i < 4; i++) begin
          if (pat_m[i][t-1]) begin
            trig_e[i]  = 1'b1;
            trig_at[i] = cyc;
            gate_on[i] = 1'b1;
          end
        end
      end
      if (!bus.play) for (int i = 0; i < 4; i++) gate_on[i] = 1'b0;
      prev_m = bus.play ? t : 0;
      if (bus.play && bpm_m != 0) begin
        k_m++;
        tick_e = ((k_m * bpm_m) / ACC_MAX) != (((k_m - 1) * bpm_m) / ACC_MAX);
      end else begin
        k_m    = 0;
        tick_e = 1'b0;
      end
      if (!bus.play) begin
        if (bus.ld_ins1) pat_m[0] = bus.data_in;
        if (bus.ld_ins2) pat_m[1] = bus.data_in;
        if (bus.ld_ins3) pat_m[2] = bus.data_in;
        if (bus.ld_ins4) pat_m[3] = bus.data_in;
        if (bus.ld_bpm)  bpm_m    = int'(bus.data_in);
      end
    end
  endtask

  task automatic run(input int n);
    logic [3:0] gate_e;
    logic [7:0] led_e;
    int t;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      t = int'(bus.timing);
      for (int i = 0; i < 4; i++)
        gate_e[i] = gate_on[i] && ((cyc - trig_at[i]) < GATE);
      led_e = 8'h00;
      if (t >= 1 && t <= 8) led_e[t-1] = 1'b1;
      check("beat_tick", bus.beat_tick, tick_e);
      check("trig",      bus.trig,      trig_e);
      check("gate",      bus.gate,      gate_e);
      check("step_led",  bus.step_led,  led_e);
      check("bpm_zero",  bus.bpm_zero,  bpm_m == 0);
    end
  endtask

  task automatic set_ld(input logic [4:0] ld, input logic [7:0] d);
    bus.data_in = d;
    {bus.ld_bpm, bus.ld_ins4, bus.ld_ins3, bus.ld_ins2, bus.ld_ins1} = ld;
  endtask

  task automatic load(input logic [4:0] ld, input logic [7:0] d);
    set_ld(ld, d);
    run(1);
    set_ld(5'b0, d);
  endtask

  initial begin
    int first, second, cnt;
    bus.play   = 1'b0;
    bus.timing = 4'd0;

    // Reset with every strobe high: nothing may load.
    reset = 1'b0;
    set_ld(5'b11111, 8'hFF);
    run(2);
    check("reset_trig", bus.trig, 0);
    reset = 1'b1;
    set_ld(5'b0, 8'h00);
    run(1);
    check("no_load_in_reset", bus.bpm_zero, 1);

    // Tempo: bpm=120 -> 25 clocks per tick.
    load(5'b10000, 8'd120);
    bus.play = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 60; i++) begin
      run(1);
      if (bus.beat_tick) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("first_tick_delay", first, 25);
    check("tick_period", second - first, 25);
    bus.play = 1'b0;
    run(2);

    // Pattern 0000_0101 across steps 0..3.
    load(5'b00001, 8'b0000_0101);
    bus.play = 1'b1;
    cnt = 0;
    for (int s = 0; s <= 3; s++) begin
      bus.timing = 4'(s);
      for (int c = 0; c < 6; c++) begin
        run(1);
        if (bus.trig[0]) cnt++;
      end
    end
    check("pat1_trig_count", cnt, 2);
    bus.play = 1'b0;
    bus.timing = 4'd0;
    run(2);

    // bpm=0: never ticks.
    load(5'b10000, 8'd0);
    bus.play = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      run(1);
      if (bus.beat_tick) cnt++;
    end
    check("bpm0_ticks", cnt, 0);
    bus.play = 1'b0;
    run(2);

    // Loads ignored during play; dropping play kills gates and the accumulator.
    load(5'b00010, 8'h0F);
    load(5'b10000, 8'd100);
    bus.play = 1'b1;
    run(2);
    load(5'b00010, 8'hAA);
    for (int s = 1; s <= 8; s++) begin
      bus.timing = 4'(s);
      run(3);
    end
    bus.timing = 4'd1;
    run(2);
    check("gate_mid", bus.gate[1], 1);
    bus.play = 1'b0;
    run(1);
    check("gate_after_drop", bus.gate, 0);
    bus.play = 1'b1;
    run(40);
    bus.play = 1'b0;
    bus.timing = 4'd0;
    run(2);

    // Wrap 8->1 retriggers; step 9 is silent.
    load(5'b01000, 8'h81);
    bus.play = 1'b1;
    bus.timing = 4'd8; run(3);
    bus.timing = 4'd1; run(3);
    bus.timing = 4'd9; run(3);
    check("step9_led", bus.step_led, 0);
    bus.play = 1'b0;
    bus.timing = 4'd0;
    run(2);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.play = ~bus.play;
      if ($urandom_range(0, 3) == 0) bus.timing = 4'($urandom_range(0, 10));
      bus.data_in = 8'($urandom);
      bus.ld_ins1 = ($urandom_range(0, 7) == 0);
      bus.ld_ins2 = ($urandom_range(0, 7) == 0);
      bus.ld_ins3 = ($urandom_range(0, 7) == 0);
      bus.ld_ins4 = ($urandom_range(0, 7) == 0);
      bus.ld_bpm  = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 499) != 0);
      run(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
